// File: rtl/prio_ticket_queue_pkg.sv
// Shared types and helpers for the priority ticket dispatcher.
package prio_ticket_pkg;

    localparam int PTQ_NUM_PRIO = 2;
    localparam int PTQ_TICKET_W = 8;
    localparam int PTQ_PRIO_W   = (PTQ_NUM_PRIO > 1) ? $clog2(PTQ_NUM_PRIO) : 1;

    typedef logic [PTQ_TICKET_W-1:0] ticket_t;
    typedef logic [PTQ_PRIO_W-1:0]   prio_t;

    typedef enum logic {IDLE, SERVING} state_t;

    // Index of the lowest set bit; caller guarantees the vector is non-empty.
    function automatic int first_set(input logic [31:0] v);
        first_set = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) first_set = i;
        end
    endfunction

endpackage

// File: rtl/prio_ticket_queue_fifo.sv
// Single-level ticket FIFO: registered pointers, head visible with no read latency.
module ticket_fifo #(
    parameter int DEPTH    = 64,
    parameter int TICKET_W = 8,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                Clk,
    input  logic                Reset_N,
    input  logic                push,
    input  logic                pop,
    input  logic [TICKET_W-1:0] din,
    output logic [TICKET_W-1:0] dout,
    output logic [CW-1:0]       count,
    output logic                full,
    output logic                empty
);
    localparam int AW = $clog2(DEPTH);

    logic [TICKET_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_q, rd_q;
    logic [CW-1:0]       cnt_q;

    // Storage; the owner never pushes a full level, so no overflow guard here.
    always_ff @(posedge Clk) begin
        if (Reset_N && push) mem_q[wr_q] <= din;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/prio_ticket_queue.sv
// Multi-priority ticket dispatcher: issues wrapping tickets, queues them per level,
// and hands the winning head to the service desk on each Done.
// Optional aging (anti-starvation) is enabled by defining PTQ_AGING_EN.
module prio_ticket_queue
    import prio_ticket_pkg::*;
#(
    parameter int NUM_PRIO  = 2,
    parameter int DEPTH     = 64,
    parameter int TICKET_W  = 8,
    parameter int AGE_LIMIT = 4,
    localparam int PRIO_W   = (NUM_PRIO > 1) ? $clog2(NUM_PRIO) : 1,
    localparam int CNT_W    = $clog2(NUM_PRIO * DEPTH + 1)
) (
    input  logic                Clk,
    input  logic                Reset_N,
    input  logic                New,
    input  logic [PRIO_W-1:0]   New_Prio,
    input  logic                Done,
    output logic                Accepted,
    output logic [TICKET_W-1:0] Ticket,
    output logic                Drop,
    output logic                Serving,
    output logic [TICKET_W-1:0] Current_Client,
    output logic [PRIO_W-1:0]   Current_Prio,
    output logic [CNT_W-1:0]    Total_Clients,
    output logic [NUM_PRIO-1:0] Full
);
    localparam int LCW = $clog2(DEPTH + 1);

    logic [NUM_PRIO-1:0]               push, pop, lvl_full, lvl_empty, ne, win;
    logic [NUM_PRIO-1:0][TICKET_W-1:0] head;
    logic [NUM_PRIO-1:0][LCW-1:0]      lvl_cnt;
    logic [PRIO_W-1:0]                 sel;
    logic                              dispatch, accept;
    logic [CNT_W-1:0]                  total;

    state_t              state_q;
    logic [TICKET_W-1:0] next_tkt_q, tkt_q, cur_q;
    logic [PRIO_W-1:0]   cprio_q;
    logic                acc_q, drop_q, serv_q;

`ifdef PTQ_AGING_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    logic [NUM_PRIO-1:0][AGE_W-1:0] age_q;
    logic [NUM_PRIO-1:0]            forced;

    // A level is forced once it has been passed over AGE_LIMIT times.
    always_comb begin
        for (int l = 0; l < NUM_PRIO; l++)
            forced[l] = ne[l] && (age_q[l] >= AGE_W'(AGE_LIMIT));
    end

    // Skip counters: bump on each dispatch that passes a waiting level, saturate at the limit.
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            age_q <= '0;
        end else begin
            for (int l = 0; l < NUM_PRIO; l++) begin
                if (!ne[l] || (dispatch && int'(sel) == l))
                    age_q[l] <= '0;
                else if (dispatch && age_q[l] != AGE_W'(AGE_LIMIT))
                    age_q[l] <= age_q[l] + 1'b1;
            end
        end
    end
`endif

    // Level selection, dispatch decision and per-level push/pop strobes.
    always_comb begin
        ne  = ~lvl_empty;
        win = ne;
`ifdef PTQ_AGING_EN
        if (|forced) win = forced;
`endif
        sel      = PRIO_W'(first_set(32'(win)));
        dispatch = (|ne) && (state_q == IDLE || Done);
        for (int l = 0; l < NUM_PRIO; l++) begin
            push[l] = New && (int'(New_Prio) == l) && !lvl_full[l];
            pop[l]  = dispatch && (int'(sel) == l);
        end
        accept = |push;
    end

    for (genvar g = 0; g < NUM_PRIO; g++) begin : g_lvl
        ticket_fifo #(.DEPTH(DEPTH), .TICKET_W(TICKET_W)) u_fifo (
            .Clk     (Clk),
            .Reset_N (Reset_N),
            .push    (push[g]),
            .pop     (pop[g]),
            .din     (next_tkt_q),
            .dout    (head[g]),
            .count   (lvl_cnt[g]),
            .full    (lvl_full[g]),
            .empty   (lvl_empty[g])
        );
    end

    // Waiting population across all levels (desk excluded).
    always_comb begin
        total = '0;
        for (int l = 0; l < NUM_PRIO; l++) total = total + CNT_W'(lvl_cnt[l]);
    end

    // Arrival side: ticket counter and registered accept/drop pulses.
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            next_tkt_q <= '0;
            tkt_q      <= '0;
            acc_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            acc_q  <= accept;
            drop_q <= New && !accept;
            if (accept) begin
                tkt_q      <= next_tkt_q;
                next_tkt_q <= next_tkt_q + 1'b1;
            end
        end
    end

    // Desk FSM: pull the selected head when idle or when the current client is done.
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q <= IDLE;
            serv_q  <= 1'b0;
            cur_q   <= '0;
            cprio_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dispatch) begin
                        cur_q   <= head[sel];
                        cprio_q <= sel;
                        serv_q  <= 1'b1;
                        state_q <= SERVING;
                    end
                end
                SERVING: begin
                    if (dispatch) begin
                        cur_q   <= head[sel];
                        cprio_q <= sel;
                    end else if (Done) begin
                        serv_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Accepted       = acc_q;
    assign Ticket         = tkt_q;
    assign Drop           = drop_q;
    assign Serving        = serv_q;
    assign Current_Client = cur_q;
    assign Current_Prio   = cprio_q;
    assign Total_Clients  = total;
    assign Full           = lvl_full;

endmodule

// File: tb/tb_prio_ticket_queue.sv
// Scoreboard bench for prio_ticket_queue: a queue-based reference model pushes the
// expected post-edge outputs; a monitor pops and compares on every falling edge.
module tb_prio_ticket_queue;
    localparam int NP        = 2;
    localparam int DEPTH     = 64;
    localparam int TW        = 8;
    localparam int AGE_LIMIT = 4;
    localparam int PW        = 1;
    localparam int CW        = $clog2(NP * DEPTH + 1);

    logic          Clk, Reset_N, New, Done;
    logic [PW-1:0] New_Prio;
    logic          Accepted, Drop, Serving;
    logic [TW-1:0] Ticket, Current_Client;
    logic [PW-1:0] Current_Prio;
    logic [CW-1:0] Total_Clients;
    logic [NP-1:0] Full;

    prio_ticket_queue #(.NUM_PRIO(NP), .DEPTH(DEPTH), .TICKET_W(TW), .AGE_LIMIT(AGE_LIMIT)) dut (
        .Clk(Clk), .Reset_N(Reset_N), .New(New), .New_Prio(New_Prio), .Done(Done),
        .Accepted(Accepted), .Ticket(Ticket), .Drop(Drop), .Serving(Serving),
        .Current_Client(Current_Client), .Current_Prio(Current_Prio),
        .Total_Clients(Total_Clients), .Full(Full)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int acc; int drop; int tkt; int serv; int cur; int cprio; int total; int full;
    } exp_t;

    exp_t eq[$];
    int   total_n = 0;
    int   bad_n   = 0;

    // Reference model state: one queue per level, the desk, the next ticket.
    int mq[NP][$];
    int nxt = 0, m_serv = 0, m_cur = 0, m_cprio = 0;
    int age[NP];

    task automatic chk(input string nm, input int act, input int want);
        total_n++;
        if (act != want) begin
            bad_n++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, want, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit nw, input int pr, input bit dn);
        exp_t e;
        int   sz[NP];
        bit   any;
        int   sel;
        e = '{default: 0};
        any = 0;
        sel = -1;
        if (!rst) begin
            for (int l = 0; l < NP; l++) begin
                mq[l].delete();
                age[l] = 0;
            end
            nxt = 0; m_serv = 0; m_cur = 0; m_cprio = 0;
        end else begin
            for (int l = 0; l < NP; l++) begin
                sz[l] = mq[l].size();
                if (sz[l] > 0) any = 1;
            end
            if (any && (m_serv == 0 || dn)) begin
                for (int l = NP - 1; l >= 0; l--) if (sz[l] > 0) sel = l;
`ifdef PTQ_AGING_EN
                for (int l = NP - 1; l >= 0; l--) if (sz[l] > 0 && age[l] >= AGE_LIMIT) sel = l;
`endif
                m_cur   = mq[sel].pop_front();
                m_cprio = sel;
                m_serv  = 1;
            end else if (m_serv != 0 && dn) begin
                m_serv = 0;
            end
            for (int l = 0; l < NP; l++) begin
                if (sz[l] == 0 || l == sel) age[l] = 0;
                else if (sel >= 0)          age[l] = age[l] + 1;
            end
            if (nw) begin
                if (pr < NP && sz[pr] < DEPTH) begin
                    mq[pr].push_back(nxt);
                    e.acc = 1;
                    e.tkt = nxt;
                    nxt   = (nxt + 1) % (1 << TW);
                end else begin
                    e.drop = 1;
                end
            end
        end
        e.serv  = m_serv;
        e.cur   = m_cur;
        e.cprio = m_cprio;
        for (int l = 0; l < NP; l++) begin
            e.total += mq[l].size();
            if (mq[l].size() == DEPTH) e.full |= (1 << l);
        end
        eq.push_back(e);
    endtask

    task automatic cyc(input bit rst, input bit nw, input int pr, input bit dn);
        @(negedge Clk);
        Reset_N  = rst;
        New      = nw;
        New_Prio = PW'(pr);
        Done     = dn;
        @(posedge Clk);
        model_step(rst, nw, pr, dn);
    endtask

    // Monitor: compare every registered output against the model's expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (eq.size() > 0) begin
                e = eq.pop_front();
                chk("accepted", int'(Accepted), e.acc);
                chk("drop", int'(Drop), e.drop);
                if (e.acc != 0) chk("ticket", int'(Ticket), e.tkt);
                chk("serving", int'(Serving), e.serv);
                chk("current_client", int'(Current_Client), e.cur);
                chk("current_prio", int'(Current_Prio), e.cprio);
                chk("total_clients", int'(Total_Clients), e.total);
                chk("full", int'(Full), e.full);
            end
        end
    end

    initial begin
        Reset_N = 1'b0; New = 1'b0; New_Prio = '0; Done = 1'b0;

        // Reset held two cycles with New asserted: nothing accepted, ticket stays 0.
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);

        // Five at prio 1, two at prio 0, then step the desk with Done.
        repeat (5) cyc(1, 1, 1, 0);
        repeat (2) cyc(1, 1, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
        repeat (7) begin
            cyc(1, 0, 0, 1);
            cyc(1, 0, 0, 0);
        end

        // Fill prio 0 past capacity with the desk occupied, then prio 1 still accepted.
        cyc(0, 0, 0, 0);
        repeat (70) cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 1, 1, 0);
        repeat (3) cyc(1, 0, 0, 0);
        repeat (140) cyc(1, 0, 0, 1);

        // Done and New together with empty queues; Done while idle is ignored.
        cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 1);
        repeat (3) cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);

        // Prio 0 kept busy while one prio-1 client waits.
        cyc(0, 0, 0, 0);
        repeat (10) cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 0);
        repeat (12) cyc(1, 1, 0, 1);
        repeat (80) cyc(1, 0, 0, 1);

        // Long random traffic: ticket wrap and FIFO order across it.
        cyc(0, 0, 0, 0);
        repeat (700) cyc(1, $urandom_range(0, 99) < 60, int'($urandom_range(0, 1)), $urandom_range(0, 99) < 45);

        // Random traffic with occasional mid-service reset.
        repeat (800) cyc($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 50,
                         int'($urandom_range(0, 1)), $urandom_range(0, 99) < 30);

        // Arrival pressure with rare Done: exercises full levels and drops.
        repeat (400) cyc(1, $urandom_range(0, 99) < 90, int'($urandom_range(0, 1)), $urandom_range(0, 99) < 10);

        repeat (2) cyc(1, 0, 0, 0);
        @(negedge Clk);
        @(negedge Clk);
        chk("scoreboard_drained", eq.size(), 0);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
